universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised N-bit universal shift register: hold, shift right, shift left and parallel load, with a synchronous clear and a frame counter that flags every N completed shifts. It generalises the free-running right-shift register into the serializer/deserializer building block for the Registers_and_Counters library. A parent block drives `mode` every cycle and samples `q`, the serial outputs or `frame_done`.

## Interface
- `N`, default 8: register width in bits; legal N ≥ 2.
- `CNT_W`, default `$clog2(N)`: frame counter width. Derived; not overridden.

- `clk` input 1: single clock, rising edge.
- `n_reset` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous clear of `q` and `count`.
- `mode` input 2: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `rot` input 1: rotate qualifier for the shift modes; effective only with `USR_ROTATE_EN`.
- `sin_r` input 1: serial input for a right shift; enters at bit N-1.
- `sin_l` input 1: serial input for a left shift; enters at bit 0.
- `par_in` input N: parallel load data.
- `q` output N: register contents.
- `sout_r` output 1: equals `q[0]`, the bit leaving on the next right shift.
- `sout_l` output 1: equals `q[N-1]`, the bit leaving on the next left shift.
- `count` output CNT_W: number of shifts since the last load, clear or frame end.
- `frame_done` output 1: single-cycle pulse after the Nth shift of a frame.

## Operation
- Reset (`n_reset`=0, asynchronous): `q`=0, `count`=0, `frame_done`=0. All values hold while reset is asserted.
- Priority per edge: `clr` > load > shift > hold.
- `clr`=1: `q`←0, `count`←0, `frame_done`←0, regardless of `mode`.
- Load (11): `q`←`par_in`, `count`←0. Starts a new frame.
- Shift right (01): `q`←{`sin_r`, `q[N-1:1]`}.
- Shift left (10): `q`←{`q[N-2:0]`, `sin_l`}.
- Hold (00): `q` and `count` unchanged.
- Frame counter:
  - Increments on every shift, in either direction, mixed freely.
  - On a shift with `count`=N-1: `count` wraps to 0 and `frame_done`←1.
  - `frame_done`←0 on every other edge, so it is never high for two consecutive cycles unless consecutive frames complete. That is only possible when N=1, which is illegal.
- Load or clear in the same cycle as a would-be Nth shift: no shift occurs, `count`←0, no `frame_done`.
- `sout_r` and `sout_l` are combinational taps of registered `q`. There is no other combinational path from inputs to outputs.

## Timing
- Latency: every input change is visible on `q`/`count` one cycle after the sampling edge.
- `frame_done` rises on the same edge that writes the Nth shifted bit into `q`. In that cycle `q` holds the complete frame and `count`=0.
- Reset assertion mid-frame discards the frame immediately.
- The first edge after `n_reset` deassertion is a normal functional edge.
- No handshake; `mode` is sampled on every edge.

## Configuration
- `USR_ROTATE_EN` defined:
  - Shift right with `rot`=1: the bit entering at N-1 is the old `q[0]`, and `sin_r` is ignored.
  - Shift left with `rot`=1: the bit entering at 0 is the old `q[N-1]`, and `sin_l` is ignored.
  - Rotations count toward the frame like ordinary shifts.
- `USR_ROTATE_EN` undefined: `rot` is ignored and its port remains present, so the interface is stable across builds.

## Structure
- Shared package `shift_reg_pkg`:
  - mode encodings `MODE_HOLD`, `MODE_SHR`, `MODE_SHL`, `MODE_LOAD`.
  - mode typedef `usr_mode_t` (2 bits).
- One sub-module, `frame_counter`: modulo-N counter with enable, synchronous clear and wrap pulse. Reusable by the later SPI serializer.
- Next-state data mux and the `q` register live in the top module.

## Test plan
- Reset: hold `n_reset`=0 with `par_in`=0xFF and `mode`=11 -> `q`=0x00, `count`=0, `frame_done`=0; the first edge after release loads 0xFF.
- Load and hold (N=8): load 0xA5, then `mode`=00 for 5 cycles -> `q`=0xA5 throughout; `sout_r`=1, `sout_l`=1.
- Directional shifts:
  - from 0xA5, shift right with `sin_r`=0 -> `q`=0x52;
  - then shift left with `sin_l`=1 -> `q`=0xA5;
  - `count`=2.
- Frame: load 0x00, then 8 right shifts with `sin_r`=1 -> `q`=0xFF and `frame_done`=1 on the 8th edge only, `count`=0. A 9th shift gives `count`=1 and `frame_done`=0.
- Priority and mid-frame abort:
  - after 7 shifts, assert `clr` together with `mode`=11 -> `q`=0x00, `count`=0, no `frame_done`;
  - repeat and pulse `n_reset` low mid-cycle -> immediate `q`=0.
- Rotate (`USR_ROTATE_EN`): load 0x81, shift right with `rot`=1 and `sin_r`=0 -> `q`=0xC0; without the macro -> `q`=0x40.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for the Registers_and_Counters shift-register blocks.
//   usr_mode_t : 2-bit operating mode (hold / shift right / shift left / load)
//   is_shift() : true for either shift direction
// ----------------------------------------------------------------------------
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_t;

  function automatic logic is_shift(input usr_mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// ----------------------------------------------------------------------------
// frame_counter
// Modulo-N counter with enable, synchronous clear and a registered wrap pulse.
//   clk, n_reset : clock and asynchronous active-low reset
//   clr          : synchronous clear (wins over en, suppresses wrap)
//   en           : count one step
//   count        : current count, 0 .. N-1
//   wrap         : one-cycle pulse on the edge where count wraps N-1 -> 0
// ----------------------------------------------------------------------------
module frame_counter #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;

  // Next-state for counter and wrap pulse
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end else if (en) begin
      if (count_q == CNT_W'(N - 1)) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
        wrap_d  = 1'b0;
      end
    end else begin
      count_d = count_q;
      wrap_d  = 1'b0;
    end
  end

  // Counter and wrap pulse registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/universal_shift_reg.sv
// ----------------------------------------------------------------------------
// universal_shift_reg
// N-bit universal shift register: hold, shift right, shift left, parallel
// load, synchronous clear, and a frame counter pulsing after every N shifts.
// Optional feature macro: USR_ROTATE_EN (rot selects rotate in shift modes).
//   clk, n_reset   : clock and asynchronous active-low reset
//   clr            : synchronous clear of q and count (highest priority)
//   mode[1:0]      : 00 hold, 01 shift right, 10 shift left, 11 load
//   rot            : rotate qualifier (ignored unless USR_ROTATE_EN)
//   sin_r, sin_l   : serial inputs entering at bit N-1 / bit 0
//   par_in[N-1:0]  : parallel load data
//   q[N-1:0]       : register contents
//   sout_r, sout_l : q[0] / q[N-1]
//   count          : shifts since last load, clear or frame end
//   frame_done     : pulse on the edge that completes the Nth shift
// ----------------------------------------------------------------------------
module universal_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int N = 8,
  localparam int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [N-1:0]     par_in,
  output logic [N-1:0]     q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] count,
  output logic             frame_done
);

  usr_mode_t    mode_s;
  logic [N-1:0] q_q, q_d;
  logic         shr_in_s;
  logic         shl_in_s;
  logic         cnt_clr_s;
  logic         cnt_en_s;

  assign mode_s = usr_mode_t'(mode);

`ifdef USR_ROTATE_EN
  // Rotation recirculates the bit that is leaving the opposite end.
  assign shr_in_s = rot ? q_q[0]   : sin_r;
  assign shl_in_s = rot ? q_q[N-1] : sin_l;
`else
  // rot stays on the port list so the interface matches both builds.
  logic unused_rot_s;
  assign unused_rot_s = rot;
  assign shr_in_s     = sin_r;
  assign shl_in_s     = sin_l;
`endif

  // Next-state data mux: clr > load > shift > hold
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else begin
      case (mode_s)
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = {shr_in_s, q_q[N-1:1]};
        MODE_SHL:  q_d = {q_q[N-2:0], shl_in_s};
        MODE_LOAD: q_d = par_in;
        default:   q_d = q_q;
      endcase
    end
  end

  // Data register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // A load restarts the frame, so it clears the counter just like clr.
  assign cnt_clr_s = clr || (mode_s == MODE_LOAD);
  assign cnt_en_s  = is_shift(mode_s);

  frame_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_frame_counter (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .count   (count),
    .wrap    (frame_done)
  );

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[N-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_universal_shift_reg
// Directed stimulus for universal_shift_reg (N=8). Each stimulus step pushes
// its hand-computed expected response into a scoreboard queue; a separate
// monitor pops and compares shortly after every rising edge.
// ----------------------------------------------------------------------------
module tb_universal_shift_reg;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       clr;
  logic [1:0] mode;
  logic       rot;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] par_in;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [2:0] count;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] q;
    logic [2:0] cnt;
    logic       fd;
    string      name;
  } exp_t;

  exp_t sb[$];

  // Right-shift fill pattern from 0x00 with sin_r=1
  logic [7:0] fill_tbl [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

  universal_shift_reg #(.N(N)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .clr        (clr),
    .mode       (mode),
    .rot        (rot),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
    .par_in     (par_in),
    .q          (q),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .count      (count),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue its expectation
  task automatic step(input logic [1:0] m, input logic [7:0] p, input logic sr,
                      input logic sl, input logic r, input logic c,
                      input logic [7:0] eq, input logic [2:0] ec, input logic ef,
                      input string nm);
    exp_t e;
    @(negedge clk);
    mode   = m;
    par_in = p;
    sin_r  = sr;
    sin_l  = sl;
    rot    = r;
    clr    = c;
    e.q = eq; e.cnt = ec; e.fd = ef; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare the oldest expectation against the post-edge outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".q"},      32'(q),          32'(e.q));
        chk({e.name, ".count"},  32'(count),      32'(e.cnt));
        chk({e.name, ".fdone"},  32'(frame_done), 32'(e.fd));
        chk({e.name, ".sout_r"}, 32'(sout_r),     32'(e.q[0]));
        chk({e.name, ".sout_l"}, 32'(sout_l),     32'(e.q[7]));
      end
    end
  end

  initial begin
    n_reset = 1'b0;
    clr     = 1'b0;
    mode    = 2'b11;
    rot     = 1'b0;
    sin_r   = 1'b0;
    sin_l   = 1'b0;
    par_in  = 8'hFF;

    // Reset holds everything at zero despite a pending load
    step(2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "rst0");
    step(2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "rst1");
    @(posedge clk); #2; n_reset = 1'b1;
    step(2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0, "post_rst_load");

    // Load and hold
    step(2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, "load_a5");
    for (int i = 0; i < 5; i++)
      step(2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, "hold");

    // Directional shifts
    step(2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h52, 3'd1, 1'b0, "shr");
    step(2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd2, 1'b0, "shl");
    step(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd2, 1'b0, "hold_cnt");

    // Full frame of right shifts, then one more
    step(2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "load_00");
    for (int i = 0; i < 8; i++)
      step(2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, fill_tbl[i], 3'((i + 1) % 8),
           (i == 7) ? 1'b1 : 1'b0, "frame");
    step(2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b0, "frame9");

    // Clear with load on the would-be 8th shift
    step(2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "load_00b");
    for (int i = 0; i < 7; i++)
      step(2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, fill_tbl[i], 3'(i + 1), 1'b0, "pre_clr");
    step(2'b11, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, "clr_prio");
    step(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "after_clr");

    // Load on the would-be 8th shift; mixed directions count together
    for (int i = 0; i < 7; i++)
      step((i % 2 == 0) ? 2'b01 : 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
           8'h00, 3'(i + 1), 1'b0, "mixed");
    step(2'b11, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 3'd0, 1'b0, "load_abort");

    // Mid-cycle asynchronous reset
    step(2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "load_00c");
    for (int i = 0; i < 7; i++)
      step(2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, fill_tbl[i], 3'(i + 1), 1'b0, "pre_rst");
    @(posedge clk); #3;
    n_reset = 1'b0;
    #1;
    chk("async_rst.q",     32'(q),          32'h0);
    chk("async_rst.count", 32'(count),      32'h0);
    chk("async_rst.fdone", 32'(frame_done), 32'h0);
    step(2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "rst_held");
    @(posedge clk); #2; n_reset = 1'b1;
    step(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "rst_release");

    // Rotate qualifier
    step(2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 3'd0, 1'b0, "load_81");
`ifdef USR_ROTATE_EN
    step(2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC0, 3'd1, 1'b0, "rot_r");
    step(2'b10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 3'd2, 1'b0, "rot_l");
`else
    step(2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 3'd1, 1'b0, "rot_r");
    step(2'b10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 3'd2, 1'b0, "rot_l");
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
